// File: rtl/mcp3204_spi_target_pkg.sv
// Shared types and constants for the MCP3204 serial-target model.
// The differential pair maps are used only when MCP3204_TGT_DIFF_EN is defined.
package mcp3204_pkg;

    localparam int MCP_DATA_BITS = 12;
    localparam int MCP_CMD_BITS  = 4;   // SGL, D2, D1, D0 after the start bit

    // Pseudo-differential pairing, indexed by {D1,D0} in 2-bit slots:
    // 00 -> CH0-CH1, 01 -> CH1-CH0, 10 -> CH2-CH3, 11 -> CH3-CH2
    localparam logic [7:0] MCP_DIFF_POS_MAP = 8'b11_10_01_00;
    localparam logic [7:0] MCP_DIFF_NEG_MAP = 8'b10_11_00_01;

    typedef logic [MCP_DATA_BITS-1:0] mcp_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_CMD,
        ST_SAMPLE,
        ST_SHIFT,
        ST_TAIL
    } mcp_state_e;

    function automatic logic [1:0] diff_pos(input logic [1:0] chan);
        return MCP_DIFF_POS_MAP[{chan, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] diff_neg(input logic [1:0] chan);
        return MCP_DIFF_NEG_MAP[{chan, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/mcp3204_spi_target_if.sv
// SPI pins, channel inputs and command/status outputs of the MCP3204 target.
// slave = the emulated converter, master = the SPI master / fabric side.
interface mcp3204_spi_target_if;
    import mcp3204_pkg::*;

    logic       sclk;
    logic       ncs;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    mcp_word_t  ain0;
    mcp_word_t  ain1;
    mcp_word_t  ain2;
    mcp_word_t  ain3;
    logic       cmd_valid;
    logic [1:0] cmd_chan;
    logic       cmd_sgl;
    logic       frame_abort;

    modport slave (
        input  sclk, ncs, mosi, ain0, ain1, ain2, ain3,
        output miso, miso_oe, cmd_valid, cmd_chan, cmd_sgl, frame_abort
    );

    modport master (
        output sclk, ncs, mosi, ain0, ain1, ain2, ain3,
        input  miso, miso_oe, cmd_valid, cmd_chan, cmd_sgl, frame_abort
    );

endinterface

// File: rtl/mcp3204_spi_target_spi_edge_sync.sv
// Synchronizer and edge detector for the asynchronous SPI pins.
// SYNC_STAGES must be at least 2.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic ncs_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic sync_mosi_o
);

    // Bit layout of each stage: {mosi, ncs, sclk}.
    // nCS resets to "selected" (0) so that a chip select held low across a
    // reset never looks like a fresh fall; a new frame needs a real high->low.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic [2:0] q;
            if (gi == 0) begin : g_first
                // first flop of the chain samples the raw pins
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) q <= 3'b000;
                    else       q <= {mosi_i, ncs_i, sclk_i};
                end
            end else begin : g_next
                // subsequent flops shift the chain along
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) q <= 3'b000;
                    else       q <= g_stage[gi-1].q;
                end
            end
        end
    endgenerate

    logic [2:0] sync_w;
    logic       sclk_prev_q;
    logic       ncs_prev_q;

    assign sync_w = g_stage[SYNC_STAGES-1].q;

    // previous synchronized levels for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_prev_q <= sync_w[0];
            ncs_prev_q  <= sync_w[1];
        end
    end

    assign sclk_rise_o = sync_w[0] & ~sclk_prev_q;
    assign sclk_fall_o = ~sync_w[0] & sclk_prev_q;
    assign cs_rise_o   = sync_w[1] & ~ncs_prev_q;
    assign cs_fall_o   = ~sync_w[1] & ncs_prev_q;
    assign sync_mosi_o = sync_w[2];

endmodule

// File: rtl/mcp3204_spi_target.sv
// MCP3204 4-channel 12-bit ADC serial-target emulation.
// Decodes start/SGL/D2/D1/D0, then returns a null bit and 12 data bits MSB first.
// Optional feature: define MCP3204_TGT_DIFF_EN to return clamped pseudo-differential
// results for SGL=0; otherwise SGL=0 returns 12'h000.
module mcp3204_spi_target
    import mcp3204_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mcp3204_spi_target_if.slave  bus
);

    localparam logic [3:0] CMD_LAST    = 4'(MCP_CMD_BITS - 1);
    localparam logic [3:0] SHIFT_FIRST = 4'(MCP_DATA_BITS - 1);

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, sync_mosi;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sclk_i      (bus.sclk),
        .ncs_i       (bus.ncs),
        .mosi_i      (bus.mosi),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise),
        .sync_mosi_o (sync_mosi)
    );

    mcp_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] cmd_q, cmd_d;          // {SGL, D1}; D2 is ignored
    mcp_word_t  held_q, held_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [1:0] chan_q, chan_d;
    logic       sgl_q, sgl_d;
    logic       abort_q, abort_d;

    mcp_word_t  ain_w [4];
    logic [1:0] dec_chan;
    logic       dec_sgl;
    mcp_word_t  sel_word;

    assign ain_w[0] = bus.ain0;
    assign ain_w[1] = bus.ain1;
    assign ain_w[2] = bus.ain2;
    assign ain_w[3] = bus.ain3;

    // D0 arrives on the same edge that completes the command
    assign dec_chan = {cmd_q[0], sync_mosi};
    assign dec_sgl  = cmd_q[1];

    // word to hold for the frame, chosen from the command being completed
    always_comb begin
`ifdef MCP3204_TGT_DIFF_EN
        logic [MCP_DATA_BITS:0] diff13;
        diff13 = {1'b0, ain_w[diff_pos(dec_chan)]} - {1'b0, ain_w[diff_neg(dec_chan)]};
`endif
        sel_word = '0;
        if (dec_sgl) begin
            sel_word = ain_w[dec_chan];
        end else begin
`ifdef MCP3204_TGT_DIFF_EN
            sel_word = diff13[MCP_DATA_BITS] ? '0 : diff13[MCP_DATA_BITS-1:0];
`else
            sel_word = '0;
`endif
        end
    end

    // next-state and output decode; nCS rise overrides any same-clock SCLK edge
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        held_d      = held_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        cmd_valid_d = 1'b0;
        chan_d      = chan_q;
        sgl_d       = sgl_q;
        abort_d     = 1'b0;

        if (cs_rise) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            // TAIL means B0 has already gone out, so the frame completed
            abort_d = (state_q != ST_IDLE) && (state_q != ST_TAIL);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    oe_d   = 1'b0;
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d = ST_WAIT_START;
                        oe_d    = 1'b1;
                    end
                end
                ST_WAIT_START: begin
                    if (sclk_rise && sync_mosi) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == CMD_LAST) begin
                            held_d      = sel_word;
                            cmd_valid_d = 1'b1;
                            chan_d      = dec_chan;
                            sgl_d       = dec_sgl;
                            state_d     = ST_SAMPLE;
                            bit_cnt_d   = 4'd0;
                        end else begin
                            if (bit_cnt_q == 4'd0) cmd_d[1] = sync_mosi;
                            if (bit_cnt_q == 4'd2) cmd_d[0] = sync_mosi;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    // wait for the sampling rising edge, then drive null on the next fall
                    if (sclk_rise) begin
                        bit_cnt_d = 4'd1;
                    end else if (sclk_fall && (bit_cnt_q == 4'd1)) begin
                        miso_d    = 1'b0;
                        state_d   = ST_SHIFT;
                        bit_cnt_d = SHIFT_FIRST;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_fall) begin
                        miso_d = held_q[bit_cnt_q];
                        if (bit_cnt_q == 4'd0) state_d = ST_TAIL;
                        else                   bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                ST_TAIL: begin
                    if (sclk_fall) miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            cmd_q       <= 2'b00;
            held_q      <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            chan_q      <= 2'b00;
            sgl_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            held_q      <= held_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            cmd_valid_q <= cmd_valid_d;
            chan_q      <= chan_d;
            sgl_q       <= sgl_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.miso_oe     = oe_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_chan    = chan_q;
    assign bus.cmd_sgl     = sgl_q;
    assign bus.frame_abort = abort_q;

endmodule
